// File: rtl/turn_sequencer_if.sv
// Move handshakes plus board RAM and win-checker bus around turn_sequencer.
// master: the sequencer; slave: Player/CPU front ends, board RAM and checker.
interface turn_sequencer_if;
  logic       p_req;
  logic [1:0] p_row;
  logic [1:0] p_col;
  logic       p_ack;
  logic       p_rej;
  logic       c_req;
  logic [1:0] c_row;
  logic [1:0] c_col;
  logic       c_ack;
  logic       c_rej;
  logic       rd_en;
  logic [1:0] rd_row;
  logic [1:0] rd_col;
  logic [1:0] rd_mark;
  logic       wr_en;
  logic [1:0] wr_row;
  logic [1:0] wr_col;
  logic [1:0] wr_mark;
  logic       clear_board;
  logic       chk_start;
  logic       chk_done;
  logic       chk_win;

  modport master (
    input  p_req, p_row, p_col, c_req, c_row, c_col, rd_mark, chk_done, chk_win,
    output p_ack, p_rej, c_ack, c_rej, rd_en, rd_row, rd_col,
           wr_en, wr_row, wr_col, wr_mark, clear_board, chk_start
  );

  modport slave (
    output p_req, p_row, p_col, c_req, c_row, c_col, rd_mark, chk_done, chk_win,
    input  p_ack, p_rej, c_ack, c_rej, rd_en, rd_row, rd_col,
           wr_en, wr_row, wr_col, wr_mark, clear_board, chk_start
  );
endinterface

// File: rtl/turn_sequencer.sv
// Tic-tac-toe turn sequencer: arbitrates Player/CPU moves, validates them against the board
// RAM, writes the mark and runs the win check. Player move timeout enabled by TURN_TIMEOUT_EN.
module turn_sequencer #(
  parameter logic FIRST_TURN     = 1'b0,
  parameter int   TIMEOUT_CYCLES = 255,
  parameter int   TO_W           = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             new_game,
  turn_sequencer_if.master bus,
  output logic             turn,
  output logic [1:0]       winner,
  output logic             game_over,
  output logic             p_timeout
);

  // state | meaning
  // CLEAR | clear_board pulse, game starts afresh
  // WAIT  | sample only the requester whose side matches turn
  // READ  | rd_en for the latched cell
  // TEST  | rd_mark sampled, occupied cell rejected
  // WRITE | wr_en and ack, move count advances
  // CHK   | chk_start pulse
  // CWAIT | waiting for chk_done
  // OVER  | winner or draw declared, requests ignored
  localparam logic [2:0] CLEAR = 3'd0;
  localparam logic [2:0] WAIT  = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] TEST  = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] CHK   = 3'd5;
  localparam logic [2:0] CWAIT = 3'd6;
  localparam logic [2:0] OVER  = 3'd7;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TO_W)) begin : gBadTimeout
    $error("turn_sequencer: TIMEOUT_CYCLES must lie in 1 .. 2**TO_W-1");
  end

  logic [2:0] state;
  logic [1:0] rowQ;
  logic [1:0] colQ;
  logic [3:0] moveCnt;
  logic       pRejQ;
  logic       cRejQ;

  logic       reqSel;
  logic [1:0] rowSel;
  logic [1:0] colSel;
  logic       take;
  logic       illegal;
  logic       timeoutHit;

  assign reqSel  = turn ? bus.c_req : bus.p_req;
  assign rowSel  = turn ? bus.c_row : bus.p_row;
  assign colSel  = turn ? bus.c_col : bus.p_col;
  // A requester still holds req in the cycle its rej is visible; skip that cycle.
  assign take    = (state == WAIT) && reqSel && !pRejQ && !cRejQ;
  assign illegal = (rowSel == 2'd3) || (colSel == 2'd3);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= CLEAR;
      rowQ    <= 2'd0;
      colQ    <= 2'd0;
      moveCnt <= 4'd0;
      turn    <= FIRST_TURN;
      winner  <= 2'd2;
      pRejQ   <= 1'b0;
      cRejQ   <= 1'b0;
    end else begin
      pRejQ <= 1'b0;
      cRejQ <= 1'b0;
      if (new_game) begin
        state   <= CLEAR;
        moveCnt <= 4'd0;
        turn    <= FIRST_TURN;
        winner  <= 2'd2;
      end else begin
        case (state)
          CLEAR: state <= WAIT;
          WAIT: begin
            if (take) begin
              if (illegal) begin
                pRejQ <= !turn;
                cRejQ <= turn;
              end else begin
                rowQ  <= rowSel;
                colQ  <= colSel;
                state <= READ;
              end
            end else if (timeoutHit) begin
              turn <= 1'b1;
            end
          end
          READ: state <= TEST;
          TEST: begin
            if (bus.rd_mark != 2'd2) begin
              pRejQ <= !turn;
              cRejQ <= turn;
              state <= WAIT;
            end else begin
              state <= WRITE;
            end
          end
          WRITE: begin
            moveCnt <= (moveCnt == 4'd9) ? 4'd9 : moveCnt + 4'd1;
            state   <= CHK;
          end
          CHK: state <= CWAIT;
          CWAIT: begin
            if (bus.chk_done) begin
              if (bus.chk_win) begin
                winner <= {1'b0, turn};
                state  <= OVER;
              end else if (moveCnt == 4'd9) begin
                winner <= 2'd3;
                state  <= OVER;
              end else begin
                turn  <= !turn;
                state <= WAIT;
              end
            end
          end
          OVER: state <= OVER;
          default: state <= CLEAR;
        endcase
      end
    end
  end

`ifdef TURN_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] toCnt;
  logic            toArmed;

  assign toArmed    = (state == WAIT) && !turn && !pRejQ;
  assign timeoutHit = toArmed && !take && !new_game && (toCnt == TO_LAST);
  assign p_timeout  = timeoutHit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      toCnt <= '0;
    end else if (new_game || !toArmed || take || timeoutHit) begin
      toCnt <= '0;
    end else begin
      toCnt <= toCnt + 1'b1;
    end
  end
`else
  assign timeoutHit = 1'b0;
  assign p_timeout  = 1'b0;
`endif

  assign bus.rd_en   = (state == READ);
  assign bus.rd_row  = rowQ;
  assign bus.rd_col  = colQ;
  assign bus.wr_en   = (state == WRITE);
  assign bus.wr_row  = rowQ;
  assign bus.wr_col  = colQ;
  assign bus.wr_mark = {1'b0, turn};
  assign bus.p_ack   = (state == WRITE) && !turn;
  assign bus.c_ack   = (state == WRITE) && turn;
  assign bus.p_rej   = pRejQ;
  assign bus.c_rej   = cRejQ;
  // Held low during reset so the clear pulse lands in the first cycle after release.
  assign bus.clear_board = (state == CLEAR) && reset;
  assign bus.chk_start   = (state == CHK);
  assign game_over       = (state == OVER);

endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer: board RAM model, checker responder and a rules-level game model.
module tb_turn_sequencer;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       newGame = 1'b0;
  logic       turn;
  logic [1:0] winner;
  logic       gameOver;
  logic       pTimeout;

  int testCnt = 0;
  int failCnt = 0;

  logic [1:0] refBoard [9];
  logic       refTurn;
  int         refCount;
  logic [1:0] refWinner;
  logic       refOver;

  turn_sequencer_if bus();

  turn_sequencer #(.FIRST_TURN(1'b0), .TIMEOUT_CYCLES(10), .TO_W(8)) dut (
    .clock(clock), .reset(reset), .new_game(newGame), .bus(bus),
    .turn(turn), .winner(winner), .game_over(gameOver), .p_timeout(pTimeout)
  );

  always #5 clock = ~clock;

  // Board RAM: one-cycle read latency, write and clear on the clock edge.
  logic [1:0] ram [9];
  always @(posedge clock) begin
    if (bus.clear_board) begin
      for (int i = 0; i < 9; i++) ram[i] <= 2'd2;
    end else if (bus.wr_en) begin
      ram[int'(bus.wr_row) * 3 + int'(bus.wr_col)] <= bus.wr_mark;
    end
    if (bus.rd_en) bus.rd_mark <= ram[int'(bus.rd_row) * 3 + int'(bus.rd_col)];
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    testCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic bit hasLine(input logic [1:0] b [9], input logic [1:0] m);
    for (int r = 0; r < 3; r++)
      if (b[r*3] == m && b[r*3+1] == m && b[r*3+2] == m) return 1'b1;
    for (int c = 0; c < 3; c++)
      if (b[c] == m && b[c+3] == m && b[c+6] == m) return 1'b1;
    if (b[0] == m && b[4] == m && b[8] == m) return 1'b1;
    if (b[2] == m && b[4] == m && b[6] == m) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic ackOf(input logic s);
    return s ? bus.c_ack : bus.p_ack;
  endfunction

  function automatic logic rejOf(input logic s);
    return s ? bus.c_rej : bus.p_rej;
  endfunction

  task automatic refReset();
    for (int i = 0; i < 9; i++) refBoard[i] = 2'd2;
    refTurn = 1'b0;
    refCount = 0;
    refWinner = 2'd2;
    refOver = 1'b0;
  endtask

  task automatic driveReq(input logic s, input logic v, input logic [1:0] r, input logic [1:0] c);
    if (s) begin
      bus.c_req = v; bus.c_row = r; bus.c_col = c;
    end else begin
      bus.p_req = v; bus.p_row = r; bus.p_col = c;
    end
  endtask

  task automatic pulseNewGame();
    bus.p_req = 1'b0;
    bus.c_req = 1'b0;
    newGame = 1'b1;
    tick();
    newGame = 1'b0;
    check("ngClear", bus.clear_board, 1);
    check("ngWinner", winner, 2);
    check("ngTurn", turn, 0);
    check("ngOver", gameOver, 0);
    refReset();
    tick();
    check("ngClearOnce", bus.clear_board, 0);
  endtask

  // One request from the side to move, optionally with the idle side also requesting.
  task automatic playMove(input logic side, input logic [1:0] row, input logic [1:0] col,
                          input bit forceNoWin, input bit otherReq);
    bit illegal, occupied, win;
    int idx, gap;
    illegal  = (row == 2'd3) || (col == 2'd3);
    idx      = int'(row) * 3 + int'(col);
    occupied = !illegal && (refBoard[idx] != 2'd2);
    driveReq(side, 1'b1, row, col);
    if (otherReq) driveReq(!side, 1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    tick();
    check("rdEn", bus.rd_en, !illegal);
    check("rejIllegal", rejOf(side), illegal);
    check("otherIgnored1", {ackOf(!side), rejOf(!side)}, 0);
    if (illegal) begin
      bus.p_req = 1'b0; bus.c_req = 1'b0;
      tick();
      check("turnAfterRej", turn, refTurn);
      return;
    end
    check("rdAddr", {bus.rd_row, bus.rd_col}, {row, col});
    tick();
    check("testQuiet", {bus.wr_en, ackOf(side), rejOf(side)}, 0);
    tick();
    check("wrEn", bus.wr_en, !occupied);
    check("ack", ackOf(side), !occupied);
    check("rejOccupied", rejOf(side), occupied);
    check("otherIgnored3", {ackOf(!side), rejOf(!side)}, 0);
    bus.p_req = 1'b0; bus.c_req = 1'b0;
    if (occupied) begin
      tick();
      check("turnAfterOcc", turn, refTurn);
      return;
    end
    check("wrBus", {bus.wr_row, bus.wr_col, bus.wr_mark}, {row, col, 1'b0, side});
    refBoard[idx] = {1'b0, side};
    refCount++;
    tick();
    check("chkStart", bus.chk_start, 1);
    tick();
    check("chkStartOnce", bus.chk_start, 0);
    gap = $urandom_range(0, 3);
    repeat (gap) begin
      check("wrHold", {bus.wr_row, bus.wr_col, bus.wr_mark}, {row, col, 1'b0, side});
      tick();
    end
    win = !forceNoWin && hasLine(refBoard, {1'b0, side});
    bus.chk_done = 1'b1;
    bus.chk_win  = win;
    tick();
    bus.chk_done = 1'b0;
    bus.chk_win  = 1'b0;
    if (win) begin
      refOver = 1'b1; refWinner = {1'b0, side};
    end else if (refCount == 9) begin
      refOver = 1'b1; refWinner = 2'd3;
    end else begin
      refTurn = !refTurn;
    end
    check("turn", turn, refTurn);
    check("winner", winner, refWinner);
    check("gameOver", gameOver, refOver);
  endtask

  initial begin
    logic [1:0] r, c;
    bit sawTimeout;
    bus.p_req = 1'b0; bus.p_row = 2'd0; bus.p_col = 2'd0;
    bus.c_req = 1'b0; bus.c_row = 2'd0; bus.c_col = 2'd0;
    bus.chk_done = 1'b0; bus.chk_win = 1'b0;
    refReset();

    #12;
    check("rstClear", bus.clear_board, 0);
    check("rstTurn", turn, 0);
    check("rstWinner", winner, 2);
    check("rstOver", gameOver, 0);
    check("rstStrobes", {bus.rd_en, bus.wr_en, bus.chk_start, bus.p_ack, bus.c_ack, pTimeout}, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check("relClear", bus.clear_board, 1);
    tick();
    check("relClearOnce", bus.clear_board, 0);
    check("relTurn", turn, 0);

    // Directed opening: accepted move, occupied and illegal CPU moves, Player ignored on CPU turn.
    playMove(1'b0, 2'd1, 2'd1, 1'b0, 1'b0);
    playMove(1'b1, 2'd1, 2'd1, 1'b0, 1'b1);
    playMove(1'b1, 2'd3, 2'd0, 1'b0, 1'b1);
    playMove(1'b1, 2'd0, 2'd0, 1'b0, 1'b1);

    // Player wins on the fifth move; requests in OVER are ignored.
    pulseNewGame();
    playMove(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    playMove(1'b1, 2'd1, 2'd0, 1'b0, 1'b0);
    playMove(1'b0, 2'd0, 2'd1, 1'b0, 1'b0);
    playMove(1'b1, 2'd1, 2'd1, 1'b0, 1'b0);
    playMove(1'b0, 2'd0, 2'd2, 1'b0, 1'b0);
    check("winPlayer", winner, 0);
    driveReq(1'b0, 1'b1, 2'd2, 2'd2);
    driveReq(1'b1, 1'b1, 2'd2, 2'd1);
    repeat (4) begin
      tick();
      check("overIgnore", {bus.rd_en, bus.p_ack, bus.p_rej, bus.c_ack, bus.c_rej}, 0);
      check("overHold", {gameOver, winner}, {1'b1, 2'd0});
    end

    // Draw: nine moves, checker never reports a line.
    pulseNewGame();
    for (int k = 0; k < 9; k++) playMove(refTurn, 2'(k / 3), 2'(k % 3), 1'b1, 1'b0);
    check("drawWinner", winner, 3);

    // Randomized games against the rules model.
    for (int g = 0; g < 6; g++) begin
      pulseNewGame();
      for (int m = 0; m < 40 && !refOver; m++) begin
        r = 2'($urandom_range(0, 2));
        c = 2'($urandom_range(0, 2));
        if ($urandom_range(0, 7) == 0) begin
          if ($urandom_range(0, 1) == 1) r = 2'd3; else c = 2'd3;
        end
        playMove(refTurn, r, c, 1'b0, 1'($urandom_range(0, 1)));
        repeat ($urandom_range(0, 2)) tick();
      end
      check("randOver", gameOver, refOver);
      check("randWinner", winner, refWinner);
    end

    // new_game while a move is in TEST drops the pending write and ack.
    pulseNewGame();
    driveReq(1'b0, 1'b1, 2'd1, 2'd2);
    tick();
    check("mmRd", bus.rd_en, 1);
    tick();
    newGame = 1'b1;
    bus.p_req = 1'b0;
    tick();
    newGame = 1'b0;
    check("mmDrop", {bus.wr_en, bus.p_ack}, 0);
    check("mmClear", bus.clear_board, 1);
    refReset();
    tick();
    check("mmTurn", turn, 0);

    // Async reset while the CPU move waits in CWAIT.
    playMove(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    driveReq(1'b1, 1'b1, 2'd2, 2'd2);
    repeat (3) tick();
    bus.c_req = 1'b0;
    repeat (2) tick();
    check("cwTurn", turn, 1);
    #2 reset = 1'b0;
    #1;
    check("arTurn", turn, 0);
    check("arWinner", winner, 2);
    check("arStrobes", {bus.clear_board, bus.chk_start, bus.wr_en, bus.c_ack, gameOver}, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check("arClear", bus.clear_board, 1);
    refReset();
    tick();

`ifdef TURN_TIMEOUT_EN
    for (int k = 1; k < 10; k++) begin
      check("toEarly", pTimeout, 0);
      tick();
    end
    check("toPulse", pTimeout, 1);
    tick();
    check("toTurn", turn, 1);
    check("toOnce", pTimeout, 0);
`else
    sawTimeout = 1'b0;
    repeat (1000) begin
      sawTimeout |= pTimeout;
      tick();
    end
    check("noTimeoutPulse", sawTimeout, 0);
    check("noTimeoutTurn", turn, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
